// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU result stage.
//   DefaultWidth : default datapath width
//   alu_op_e     : 3-bit ALU operation codes carried alongside each result
//   occ_state_e  : occupancy of the 2-entry skid buffer
package alu_defs_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned OpWidth      = 3;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpXor  = 3'd2,
    OpSlt  = 3'd3,
    OpAnd  = 3'd4,
    OpNand = 3'd5,
    OpNor  = 3'd6,
    OpOr   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative flag generation for a WIDTH-bit value.
//   value_i    : value to inspect
//   zero_o     : value_i == 0
//   negative_o : sign bit of value_i
module alu_flag_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o,
  output logic             negative_o
);

  assign zero_o     = ~|value_i;
  assign negative_o = value_i[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU. Captures result, op, carry and
// overflow plus derived zero/negative flags into a 2-entry skid buffer with a
// valid/ready handshake. Also keeps a sticky overflow bit and a saturating
// count of accepted results.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake
//   in_result, in_carryout, in_overflow, in_op : captured ALU outputs
//   out_valid/out_ready   : downstream handshake
//   out_result, out_op, out_zero, out_negative, out_carryout, out_overflow
//                         : head entry fields
//   sticky_ovf, clear_sticky : sticky overflow status and its clear
//   result_count          : saturating accepted-result counter
module alu_result_stage
  import alu_defs_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_result,
  input  logic                 in_carryout,
  input  logic                 in_overflow,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [2:0]           out_op,
  output logic                 out_zero,
  output logic                 out_negative,
  output logic                 out_carryout,
  output logic                 out_overflow,
  output logic                 sticky_ovf,
  input  logic                 clear_sticky,
  output logic [CNT_WIDTH-1:0] result_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [2:0]       op;
    logic             zero;
    logic             negative;
    logic             carryout;
    logic             overflow;
  } entry_t;

  occ_state_e           state_q;
  entry_t               head_q;
  entry_t               spare_q;
  entry_t               in_entry;
  logic                 sticky_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 in_zero;
  logic                 in_negative;
  logic                 accept;
  logic                 deliver;

  alu_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .value_i   (in_result),
    .zero_o    (in_zero),
    .negative_o(in_negative)
  );

  always_comb begin
    in_entry          = '0;
    in_entry.result   = in_result;
    in_entry.op       = in_op;
    in_entry.zero     = in_zero;
    in_entry.negative = in_negative;
    in_entry.carryout = in_carryout;
    in_entry.overflow = in_overflow;
  end

  // Both handshakes depend only on registered state.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      head_q   <= '0;
      spare_q  <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_q  <= in_entry;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && deliver) begin
            head_q <= in_entry;
          end else if (accept) begin
            spare_q <= in_entry;
            state_q <= StFull;
          end else if (deliver) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (deliver) begin
            head_q  <= spare_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase

      // A set in the same cycle as a clear wins.
      if (accept && in_overflow) begin
        sticky_q <= 1'b1;
      end else if (clear_sticky) begin
        sticky_q <= 1'b0;
      end

      if (accept && (count_q != {CNT_WIDTH{1'b1}})) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign out_result   = head_q.result;
  assign out_op       = head_q.op;
  assign out_zero     = head_q.zero;
  assign out_negative = head_q.negative;
  assign out_carryout = head_q.carryout;
  assign out_overflow = head_q.overflow;
  assign sticky_ovf   = sticky_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_result = '0;
  logic        in_carryout = 1'b0;
  logic        in_overflow = 1'b0;
  logic [2:0]  in_op = '0;
  logic        out_ready = 1'b0;
  logic        clear_sticky = 1'b0;

  logic        in_ready, out_valid, out_zero, out_negative, out_carryout, out_overflow;
  logic        sticky_ovf;
  logic [31:0] out_result;
  logic [2:0]  out_op;
  logic [7:0]  result_count;

  logic        s_in_ready, s_out_valid, s_out_zero, s_out_negative, s_out_carryout;
  logic        s_out_overflow, s_sticky_ovf;
  logic [31:0] s_out_result;
  logic [2:0]  s_out_op;
  logic [2:0]  s_result_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carryout(in_carryout), .in_overflow(in_overflow),
    .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op), .out_zero(out_zero),
    .out_negative(out_negative), .out_carryout(out_carryout),
    .out_overflow(out_overflow), .sticky_ovf(sticky_ovf),
    .clear_sticky(clear_sticky), .result_count(result_count)
  );

  // Same stimulus, narrow counter to exercise saturation.
  alu_result_stage #(.CNT_WIDTH(3)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_result(in_result), .in_carryout(in_carryout), .in_overflow(in_overflow),
    .in_op(in_op), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_result(s_out_result), .out_op(s_out_op), .out_zero(s_out_zero),
    .out_negative(s_out_negative), .out_carryout(s_out_carryout),
    .out_overflow(s_out_overflow), .sticky_ovf(s_sticky_ovf),
    .clear_sticky(clear_sticky), .result_count(s_result_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a bounded queue of captured results plus status.
  typedef struct {
    logic [31:0] result;
    logic [2:0]  op;
    logic        carry;
    logic        ovf;
  } item_t;

  item_t m_q[$];
  logic  m_sticky = 1'b0;
  int    m_count = 0;
  bit    m_live = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_sticky = 1'b0;
        m_count = 0;
        m_live = 1'b1;
      end else if (m_live) begin
        automatic bit acc = in_valid && (m_q.size() < 2);
        automatic bit dlv = (m_q.size() > 0) && out_ready;
        automatic item_t it;
        it.result = in_result;
        it.op = in_op;
        it.carry = in_carryout;
        it.ovf = in_overflow;
        if (dlv) void'(m_q.pop_front());
        if (acc) m_q.push_back(it);
        if (acc && in_overflow) m_sticky = 1'b1;
        else if (clear_sticky) m_sticky = 1'b0;
        if (acc) m_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live && !reset) begin
      check("m_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
      check("m_in_ready", {31'b0, in_ready}, {31'b0, m_q.size() < 2});
      check("m_sticky", {31'b0, sticky_ovf}, {31'b0, m_sticky});
      check("m_count", {24'b0, result_count}, (m_count > 255) ? 32'd255 : m_count);
      check("m_count_small", {29'b0, s_result_count}, (m_count > 7) ? 32'd7 : m_count);
      check("m_small_valid", {31'b0, s_out_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        check("m_result", out_result, m_q[0].result);
        check("m_op", {29'b0, out_op}, {29'b0, m_q[0].op});
        check("m_zero", {31'b0, out_zero}, {31'b0, m_q[0].result == 32'd0});
        check("m_negative", {31'b0, out_negative}, {31'b0, m_q[0].result[31]});
        check("m_carry", {31'b0, out_carryout}, {31'b0, m_q[0].carry});
        check("m_ovf", {31'b0, out_overflow}, {31'b0, m_q[0].ovf});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] vals [10];
    for (int i = 0; i < 10; i++) vals[i] = 32'h1111_1111 * i + 32'h0000_0100;
    vals[3] = 32'h0;
    vals[7] = 32'hFFFF_FFFE;

    // Reset.
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_count", {24'b0, result_count}, 32'd0);
    check("rst_sticky", {31'b0, sticky_ovf}, 32'd0);
    check("rst_result", out_result, 32'd0);

    // Single accept of zero.
    in_valid = 1'b1; in_result = 32'h0; in_op = OpOr;
    cyc();
    in_valid = 1'b0;
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_zero", {31'b0, out_zero}, 32'd1);
    check("t1_neg", {31'b0, out_negative}, 32'd0);
    check("t1_op", {29'b0, out_op}, 32'd7);
    check("t1_count", {24'b0, result_count}, 32'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("t1_drained", {31'b0, out_valid}, 32'd0);

    // Backpressure fill.
    in_valid = 1'b1; in_result = 32'h8000_0001; in_op = OpAdd; in_carryout = 1'b1;
    cyc();
    in_result = 32'h0000_0005; in_op = OpSub; in_carryout = 1'b0;
    cyc();
    check("t2_full_ready", {31'b0, in_ready}, 32'd0);
    in_result = 32'hDEAD_BEEF; in_op = OpXor;
    cyc();
    in_valid = 1'b0;
    check("t2_count", {24'b0, result_count}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_result", out_result, 32'h8000_0001);
      check("t2_hold_neg", {31'b0, out_negative}, 32'd1);
      cyc();
    end
    out_ready = 1'b1;
    check("t2_head0", out_result, 32'h8000_0001);
    cyc();
    check("t2_head1", out_result, 32'h0000_0005);
    check("t2_head1_valid", {31'b0, out_valid}, 32'd1);
    cyc();
    check("t2_empty", {31'b0, out_valid}, 32'd0);

    // Streaming with simultaneous accept and deliver.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = vals[i]; in_op = 3'(i); in_carryout = i[0];
      cyc();
      check("t3_ready", {31'b0, in_ready}, 32'd1);
      check("t3_result", out_result, vals[i]);
    end
    in_valid = 1'b0;
    cyc();
    check("t3_empty", {31'b0, out_valid}, 32'd0);
    check("t3_count", {24'b0, result_count}, 32'd13);
    check("t3_count_sat", {29'b0, s_result_count}, 32'd7);

    // Sticky overflow.
    in_valid = 1'b1; in_overflow = 1'b1; in_result = 32'h7FFF_FFFF;
    cyc();
    check("t4_set", {31'b0, sticky_ovf}, 32'd1);
    clear_sticky = 1'b1;
    cyc();
    check("t4_set_wins", {31'b0, sticky_ovf}, 32'd1);
    in_valid = 1'b0;
    cyc();
    check("t4_cleared", {31'b0, sticky_ovf}, 32'd0);
    clear_sticky = 1'b0;
    cyc();
    check("t4_no_accept_no_set", {31'b0, sticky_ovf}, 32'd0);
    in_overflow = 1'b0;
    cyc();
    out_ready = 1'b0;

    // Mid-operation reset with both entries held.
    in_valid = 1'b1; in_overflow = 1'b1; in_result = 32'h1234_5678;
    cyc();
    in_overflow = 1'b0; in_result = 32'h0000_0042;
    cyc();
    in_valid = 1'b0;
    check("t5_full", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t5_valid", {31'b0, out_valid}, 32'd0);
    check("t5_ready", {31'b0, in_ready}, 32'd1);
    check("t5_count", {24'b0, result_count}, 32'd0);
    check("t5_sticky", {31'b0, sticky_ovf}, 32'd0);
    check("t5_result", out_result, 32'd0);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered stage directly downstream of the 32-bit ALU bitwise/arith units (OR32 and siblings) in the multicycle CPU. It captures the ALU result plus carry/overflow and derives zero/negative flags. A 2-entry skid buffer with valid/ready handshake decouples the ALU from the writeback/branch-compare consumer. It also keeps sticky overflow status and a saturating count of accepted results.

Parameters:
WIDTH, 32, datapath width of result and operands
CNT_WIDTH, 8, width of the accepted-result counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  stage can accept a result
in_result  input  WIDTH  ALU result
in_carryout  input  1  ALU carry out
in_overflow  input  1  ALU signed overflow
in_op  input  3  ALU operation code, passed through with the result
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_result  output  WIDTH  head result
out_op  output  3  head op code
out_zero  output  1  head result == 0
out_negative  output  1  head result[WIDTH-1]
out_carryout  output  1  head carry
out_overflow  output  1  head overflow
sticky_ovf  output  1  set by any accepted result with overflow
clear_sticky  input  1  clears sticky_ovf
result_count  output  CNT_WIDTH  saturating count of accepted results

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Everything is sampled on the clk rising edge.
- Reset: both buffer entries invalid, out_valid=0, in_ready=1 on the first cycle after reset, sticky_ovf=0, result_count=0. All out_* data fields read 0.
- Accept: a result is accepted when in_valid and in_ready are both high. Flags are computed at capture: zero = ~|in_result, negative = in_result[WIDTH-1].
- Deliver: the head entry is delivered when out_valid and out_ready are both high.
- Latency: an accepted result appears on out_* on the next cycle, i.e. 1-cycle latency into an empty stage.
- Occupancy state machine, driven by count of valid entries:
  - EMPTY: accept -> ONE.
  - ONE: accept without deliver -> FULL. Deliver without accept -> EMPTY. Both -> ONE, and the new entry becomes the head.
  - FULL: deliver -> ONE, and entry 1 moves to the head.
- Handshake signals:
  - in_ready = (state != FULL). It is registered and does not depend on out_ready in the same cycle.
  - out_valid = (state != EMPTY).
- FIFO ordering is strict. The head data is held stable while out_valid=1 and out_ready=0.
- Data fields are don't-care when out_valid=0. In practice they hold the last delivered value. The bench must not check them in that state.
- sticky_ovf:
  - Set on any accepted entry with in_overflow=1.
  - clear_sticky=1 clears it, but a simultaneous set wins, so it stays 1.
  - Only reset or clear_sticky clears it.
- result_count increments on each accept and saturates at 2^CNT_WIDTH-1; it does not wrap.
- Reset mid-operation: all entries are discarded with no delivery; state goes to EMPTY the next cycle.
- in_valid while FULL: the result is not accepted. The upstream control FSM must hold it.

Decomposition:
- Shared package/header alu_defs: WIDTH default and the 3-bit ALU op-code constants (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR).
- One sub-module, alu_flag_gen: combinational zero/negative generation from a WIDTH-bit value. It is instantiated once, on the input side, and its results are stored with each entry.

Test Plan:
- Reset then single accept: in_result=0x0000_0000, op=OR. Next cycle out_valid=1, out_zero=1, out_negative=0, result_count=1.
- Backpressure fill:
  - out_ready=0; accept 0x8000_0001 then 0x0000_0005.
  - in_ready=0 after the second accept, and a third in_valid is ignored.
  - Head=0x8000_0001 with out_negative=1, held stable for 5 cycles.
  - out_ready=1 then delivers 0x8000_0001 and 0x0000_0005 in order.
- Simultaneous accept+deliver in ONE state: stream 10 values with in_valid=out_ready=1 continuously. The outputs are the same 10 values in order, at 1 per cycle, with in_ready always 1.
- Sticky overflow:
  - Accept with in_overflow=1: sticky_ovf=1 next cycle.
  - clear_sticky=1 in the same cycle as another overflow accept: sticky_ovf stays 1.
  - clear_sticky alone: sticky_ovf=0.
- Counter saturation with CNT_WIDTH=3: 10 accepts give result_count=7.
- Mid-operation reset: with FULL state, assert reset for 1 cycle. Next cycle out_valid=0, in_ready=1, result_count=0, sticky_ovf=0.
